// File: rtl/vt52_pkg.sv
// Shared definitions for the VT52 command engine: FSM states and the
// control / escape byte values it recognises.
package vt52_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        ESC      = 3'd2,
        ESCY_ROW = 3'd3,
        ESCY_COL = 3'd4,
        FILL     = 3'd5
    } state_t;

    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_HT       = 8'h09;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_ESC      = 8'h1B;
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

endpackage

// File: rtl/vt52_addr_gen.sv
// Wrapped character-buffer address of a screen cell, relative to the
// current scroll origin.
module vt52_addr_gen #(
    parameter int ROWS      = 25,
    parameter int COLS      = 80,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7,
    parameter int ADDR_BITS = 11
) (
    input  logic [ADDR_BITS-1:0] first_char,
    input  logic [COL_BITS-1:0]  x,
    input  logic [ROW_BITS-1:0]  y,
    output logic [ADDR_BITS-1:0] addr
);
    localparam int                 TOTAL   = ROWS * COLS;
    localparam logic [ADDR_BITS:0] TOTAL_W = (ADDR_BITS+1)'(TOTAL);
    localparam logic [ADDR_BITS:0] COLS_W  = (ADDR_BITS+1)'(COLS);

    logic [ADDR_BITS:0] sum;

    // Both terms are below TOTAL, so one conditional subtract wraps the sum.
    always_comb begin
        sum = {1'b0, first_char} + (ADDR_BITS+1)'(y) * COLS_W + (ADDR_BITS+1)'(x);
        if (sum >= TOTAL_W) addr = ADDR_BITS'(sum - TOTAL_W);
        else                addr = sum[ADDR_BITS-1:0];
    end

endmodule

// File: rtl/vt52_cmd_engine.sv
// VT52 command engine: turns a byte stream into character-buffer writes,
// cursor updates and scroll-origin updates, including screen clears.
//
// Handshake: a byte on data is consumed on a rising clk edge where
// valid && ready. ready depends only on the FSM state; while it is low the
// upstream keeps data and valid stable and nothing is consumed.
module vt52_cmd_engine
    import vt52_pkg::*;
#(
    parameter int         ROWS       = 25,
    parameter int         COLS       = 80,
    parameter int         ROW_BITS   = 5,
    parameter int         COL_BITS   = 7,
    parameter int         ADDR_BITS  = 11,
    parameter int         TAB_WIDTH  = 8,
    parameter int         AUTOWRAP   = 1,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           data,
    input  logic                 valid,
    output logic                 ready,
    output logic [7:0]           new_char,
    output logic [ADDR_BITS-1:0] new_char_address,
    output logic                 new_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen,
    output logic [ADDR_BITS-1:0] new_first_char,
    output logic                 new_first_char_wen,
    output logic                 busy,
    output logic [2:0]           dbg_state
);
    localparam int                 CW        = ADDR_BITS + 1;
    localparam int                 TOTAL     = ROWS * COLS;
    localparam logic [CW-1:0]      TOTAL_W   = CW'(TOTAL);
    localparam logic [CW-1:0]      COLS_W    = CW'(COLS);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TOTAL - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
    localparam logic [COL_BITS-1:0]  COL_ONE   = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [ROW_BITS-1:0]  ROW_ONE   = ROW_BITS'(1);
    localparam logic [7:0]           ROW_MAX8  = 8'(ROWS - 1);
    localparam logic [7:0]           COL_MAX8  = 8'(COLS - 1);

    state_t                state, state_n;
    logic [COL_BITS-1:0]   cur_x, x_n;
    logic [ROW_BITS-1:0]   cur_y, y_n;
    logic [ADDR_BITS-1:0]  first_char, fc_n;
    logic [ADDR_BITS-1:0]  fill_addr, fa_n;
    logic [CW-1:0]         fill_cnt, fcnt_n;
    logic [ADDR_BITS-1:0]  cell_addr, caddr_n;
    logic [7:0]            char_n, esc_off;
    logic [CW-1:0]         fc_plus;
    logic                  cwen_n, fcwen_n, curwen_n, busy_n, do_lf, accept;
    int                    tab_pos;

    vt52_addr_gen #(
        .ROWS(ROWS), .COLS(COLS), .ROW_BITS(ROW_BITS),
        .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS)
    ) u_addr_gen (
        .first_char (first_char),
        .x          (cur_x),
        .y          (cur_y),
        .addr       (cell_addr)
    );

    assign ready = (state == IDLE) || (state == ESC) ||
                   (state == ESCY_ROW) || (state == ESCY_COL);
    assign accept         = valid && ready;
    assign new_cursor_x   = cur_x;
    assign new_cursor_y   = cur_y;
    assign new_first_char = first_char;
    assign dbg_state      = state;

    // Next-state, cursor, scroll and write-port decode for the command FSM.
    always_comb begin
        state_n  = state;
        x_n      = cur_x;
        y_n      = cur_y;
        fc_n     = first_char;
        fa_n     = fill_addr;
        fcnt_n   = fill_cnt;
        char_n   = '0;
        caddr_n  = '0;
        cwen_n   = 1'b0;
        fcwen_n  = 1'b0;
        do_lf    = 1'b0;
        tab_pos  = (int'(cur_x) / TAB_WIDTH + 1) * TAB_WIDTH;
        esc_off  = data - CHR_PRINT_LO;
        fc_plus  = {1'b0, first_char} + COLS_W;
        if (fc_plus >= TOTAL_W) fc_plus = fc_plus - TOTAL_W;

        case (state)
            INIT, FILL: begin
                // The first INIT cycle after reset only arms the full-screen count.
                if (state == INIT && fill_cnt == '0) begin
                    fcnt_n = TOTAL_W;
                end else begin
                    cwen_n  = 1'b1;
                    char_n  = CLEAR_CHAR;
                    caddr_n = fill_addr;
                    fa_n    = (fill_addr == LAST_ADDR) ? '0 : fill_addr + ADDR_ONE;
                    fcnt_n  = fill_cnt - CNT_ONE;
                    if (fill_cnt == CNT_ONE) state_n = IDLE;
                end
            end
            IDLE: if (accept) begin
                if (data >= CHR_PRINT_LO && data <= CHR_PRINT_HI) begin
                    cwen_n  = 1'b1;
                    char_n  = data;
                    caddr_n = cell_addr;
                    if (cur_x != LAST_COL) x_n = cur_x + COL_ONE;
                    else if (AUTOWRAP != 0) begin
                        x_n   = '0;
                        do_lf = 1'b1;
                    end
                end else begin
                    case (data)
                        CHR_CR:  x_n = '0;
                        CHR_LF:  do_lf = 1'b1;
                        CHR_BS:  if (cur_x != '0) x_n = cur_x - COL_ONE;
                        CHR_HT:  x_n = (tab_pos > COLS - 1) ? LAST_COL : COL_BITS'(tab_pos);
                        CHR_ESC: state_n = ESC;
                        default: ;
                    endcase
                end
            end
            ESC: if (accept) begin
                state_n = IDLE;
                case (data)
                    8'h41: if (cur_y != '0) y_n = cur_y - ROW_ONE;         // A
                    8'h42: if (cur_y != LAST_ROW) y_n = cur_y + ROW_ONE;   // B
                    8'h43: if (cur_x != LAST_COL) x_n = cur_x + COL_ONE;   // C
                    8'h44: if (cur_x != '0) x_n = cur_x - COL_ONE;         // D
                    8'h48: begin x_n = '0; y_n = '0; end                   // H
                    8'h4A: begin                                           // J
                        fa_n    = cell_addr;
                        fcnt_n  = TOTAL_W - CW'(cur_y) * COLS_W - CW'(cur_x);
                        state_n = FILL;
                    end
                    8'h4B: begin                                           // K
                        fa_n    = cell_addr;
                        fcnt_n  = COLS_W - CW'(cur_x);
                        state_n = FILL;
                    end
                    8'h45: begin                                           // E
                        x_n     = '0;
                        y_n     = '0;
                        fa_n    = first_char;
                        fcnt_n  = TOTAL_W;
                        state_n = FILL;
                    end
                    8'h59: state_n = ESCY_ROW;                             // Y
                    default: ;
                endcase
            end
            ESCY_ROW: if (accept) begin
                if (data < CHR_PRINT_LO)      y_n = '0;
                else if (esc_off > ROW_MAX8)  y_n = LAST_ROW;
                else                          y_n = esc_off[ROW_BITS-1:0];
                state_n = ESCY_COL;
            end
            ESCY_COL: if (accept) begin
                if (data < CHR_PRINT_LO)      x_n = '0;
                else if (esc_off > COL_MAX8)  x_n = LAST_COL;
                else                          x_n = esc_off[COL_BITS-1:0];
                state_n = IDLE;
            end
            default: state_n = INIT;
        endcase

        // Line feed on the bottom row scrolls: the old top row becomes the new
        // bottom row, so it is cleared starting at the old origin.
        if (do_lf) begin
            if (cur_y == LAST_ROW) begin
                fc_n    = fc_plus[ADDR_BITS-1:0];
                fcwen_n = 1'b1;
                fa_n    = first_char;
                fcnt_n  = COLS_W;
                state_n = FILL;
            end else begin
                y_n = cur_y + ROW_ONE;
            end
        end

        curwen_n = (x_n != cur_x) || (y_n != cur_y);
        busy_n   = (state_n == INIT) || (state_n == FILL);
    end

    // State, cursor, scroll origin and registered output ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= INIT;
            cur_x              <= '0;
            cur_y              <= '0;
            first_char         <= '0;
            fill_addr          <= '0;
            fill_cnt           <= '0;
            new_char           <= '0;
            new_char_address   <= '0;
            new_char_wen       <= 1'b0;
            new_cursor_wen     <= 1'b0;
            new_first_char_wen <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= state_n;
            cur_x              <= x_n;
            cur_y              <= y_n;
            first_char         <= fc_n;
            fill_addr          <= fa_n;
            fill_cnt           <= fcnt_n;
            new_char           <= char_n;
            new_char_address   <= caddr_n;
            new_char_wen       <= cwen_n;
            new_cursor_wen     <= curwen_n;
            new_first_char_wen <= fcwen_n;
            busy               <= busy_n;
        end
    end

endmodule

// File: tb/tb_vt52_cmd_engine.sv
// Directed bench for vt52_cmd_engine. Writes, cursor pulses and scroll
// pulses are logged as one ordered event stream and compared against a
// hand-built expected stream.
module tb_vt52_cmd_engine;

    logic        clk;
    logic        rstn;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [7:0]  new_char;
    logic [10:0] new_char_address;
    logic        new_char_wen;
    logic [6:0]  new_cursor_x;
    logic [4:0]  new_cursor_y;
    logic        new_cursor_wen;
    logic [10:0] new_first_char;
    logic        new_first_char_wen;
    logic        busy;
    logic [2:0]  dbg_state;

    // event encoding: [20:19] kind (1 write, 2 cursor, 3 origin), [18:0] payload
    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_cycles = 0;
    int          last_wait = 0;
    int          b0;

    vt52_cmd_engine #(
        .ROWS(25), .COLS(80), .ROW_BITS(5), .COL_BITS(7), .ADDR_BITS(11),
        .TAB_WIDTH(8), .AUTOWRAP(1), .CLEAR_CHAR(8'h20)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .data               (data),
        .valid              (valid),
        .ready              (ready),
        .new_char           (new_char),
        .new_char_address   (new_char_address),
        .new_char_wen       (new_char_wen),
        .new_cursor_x       (new_cursor_x),
        .new_cursor_y       (new_cursor_y),
        .new_cursor_wen     (new_cursor_wen),
        .new_first_char     (new_first_char),
        .new_first_char_wen (new_first_char_wen),
        .busy               (busy),
        .dbg_state          (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (new_char_wen)       obs_q.push_back({2'd1, new_char_address, new_char});
        if (new_cursor_wen)     obs_q.push_back({2'd2, 7'd0, new_cursor_x, new_cursor_y});
        if (new_first_char_wen) obs_q.push_back({2'd3, new_first_char, 8'd0});
        if (busy) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_w(input int a, input logic [7:0] c);
        exp_q.push_back({2'd1, 11'(a), c});
    endtask

    task automatic exp_c(input int x, input int y);
        exp_q.push_back({2'd2, 7'd0, 7'(x), 5'(y)});
    endtask

    task automatic exp_f(input int a);
        exp_q.push_back({2'd3, 11'(a), 8'd0});
    endtask

    task automatic exp_fill(input int start, input int count);
        int a;
        a = start;
        for (int i = 0; i < count; i++) begin
            exp_w(a, 8'h20);
            a = (a == 1999) ? 0 : a + 1;
        end
    endtask

    task automatic compare_events(input string tag);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        check({tag, "_diffs"}, nbad, 0);
        if (first >= 0)
            $display("  %s first diff at %0d: got %h want %h", tag, first, obs_q[first], exp_q[first]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 5000) check("send_timeout", ready, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, ready, 1);
        tick(2);
    endtask

    initial begin
        rstn  = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        tick(3);

        // reset state
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_wen", new_char_wen, 0);
        check("rst_cwen", new_cursor_wen, 0);
        check("rst_fcwen", new_first_char_wen, 0);
        check("rst_cursor", {new_cursor_x, new_cursor_y}, 0);
        check("rst_first", new_first_char, 0);
        check("rst_state", dbg_state, 0);
        check("rst_events", obs_q.size(), 0);

        // power-up clear: 2000 blanks at 0..1999, busy for 2000 cycles
        b0   = busy_cycles;
        rstn = 1'b1;
        wait_ready("init");
        exp_fill(0, 2000);
        compare_events("init");
        check("init_busy_cycles", busy_cycles - b0, 2000);
        check("init_busy_low", busy, 0);

        // goto (79,0); row byte leaves y unchanged so only one pulse
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h20); send_byte(8'h6F);
        wait_ready("goto79");
        exp_c(79, 0);
        compare_events("goto79");

        // 'A' in the last column wraps to the next line
        send_byte(8'h41);
        wait_ready("wrap_a");
        exp_w(79, 8'h41);
        exp_c(0, 1);
        compare_events("wrap_a");

        // ESC K at (75,3): 5 blanks at 315..319, then held 'Q' lands at 315
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h23); send_byte(8'h6B);
        wait_ready("goto75");
        exp_c(0, 3);
        exp_c(75, 3);
        compare_events("goto75");
        b0 = busy_cycles;
        send_byte(8'h1B); send_byte(8'h4B); send_byte(8'h51);
        check("k_stall", last_wait, 5);
        wait_ready("esc_k");
        exp_fill(315, 5);
        exp_w(315, 8'h51);
        exp_c(76, 3);
        compare_events("esc_k");
        check("k_busy_cycles", busy_cycles - b0, 5);

        // direct cursor addressing, in range and clamped
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h25); send_byte(8'h2A);
        wait_ready("escy");
        exp_c(76, 5);
        exp_c(10, 5);
        compare_events("escy");
        check("escy_x", new_cursor_x, 10);
        check("escy_y", new_cursor_y, 5);
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h7F); send_byte(8'h7F);
        wait_ready("escy_clamp");
        exp_c(10, 24);
        exp_c(79, 24);
        compare_events("escy_clamp");

        // control bytes: BS, CR, HT, CR, BS at 0 (no pulse), ignored 0x01
        send_byte(8'h08); send_byte(8'h0D); send_byte(8'h09);
        send_byte(8'h0D); send_byte(8'h08); send_byte(8'h01);
        wait_ready("ctrl");
        exp_c(78, 24);
        exp_c(0, 24);
        exp_c(8, 24);
        exp_c(0, 24);
        compare_events("ctrl");

        // tab clamp, saturating escape moves, ignored escape byte
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h38); send_byte(8'h6D);
        send_byte(8'h09);
        send_byte(8'h1B); send_byte(8'h41);
        send_byte(8'h1B); send_byte(8'h42);
        send_byte(8'h1B); send_byte(8'h42);
        send_byte(8'h1B); send_byte(8'h43);
        send_byte(8'h1B); send_byte(8'h44);
        send_byte(8'h1B); send_byte(8'h5A);
        wait_ready("esc_moves");
        exp_c(77, 24);
        exp_c(79, 24);
        exp_c(79, 23);
        exp_c(79, 24);
        exp_c(78, 24);
        compare_events("esc_moves");

        // LF on the bottom row scrolls: origin 80, old top row 0..79 cleared
        send_byte(8'h0A);
        wait_ready("scroll");
        exp_f(80);
        exp_fill(0, 80);
        compare_events("scroll");
        check("scroll_origin", new_first_char, 80);
        check("scroll_y", new_cursor_y, 24);

        // ESC E: home plus full clear from origin 80, wrapping past 1999
        send_byte(8'h1B); send_byte(8'h45);
        wait_ready("esc_e");
        exp_c(0, 0);
        exp_fill(80, 2000);
        compare_events("esc_e");

        // home cell now sits at address 80
        send_byte(8'h48);
        wait_ready("origin_print");
        exp_w(80, 8'h48);
        exp_c(1, 0);
        compare_events("origin_print");

        // last cell (79,24) wraps to address 79; autowrap scrolls again
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h38); send_byte(8'h6F);
        send_byte(8'h49);
        wait_ready("wrap_scroll");
        exp_c(1, 24);
        exp_c(79, 24);
        exp_w(79, 8'h49);
        exp_c(0, 24);
        exp_f(160);
        exp_fill(80, 80);
        compare_events("wrap_scroll");

        // ESC J at (0,24), origin 160: fill starts at 80; reset it mid-way
        send_byte(8'h1B); send_byte(8'h4A);
        tick(10);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_wen", new_char_wen, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_state", dbg_state, 0);
        check("abort_first", new_first_char, 0);
        check("j_partial", obs_q.size(), 9);
        if (obs_q.size() > 0) check("j_first_write", obs_q[0], {2'd1, 11'd80, 8'h20});
        obs_q.delete();
        exp_q.delete();
        tick(5);
        check("rst_quiet", obs_q.size(), 0);

        // INIT restarts from address 0
        rstn = 1'b1;
        wait_ready("reinit");
        exp_fill(0, 2000);
        compare_events("reinit");

        send_byte(8'h42);
        wait_ready("post_reset");
        exp_w(0, 8'h42);
        exp_c(1, 0);
        compare_events("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vt52_cmd_engine.md
VT52_CMD_ENGINE -- requirements
Module: vt52_cmd_engine

Interface
REQ-001 SHALL have parameter ROWS, default 25: text rows.
REQ-002 SHALL have parameter COLS, default 80: text columns.
REQ-003 SHALL have parameters ROW_BITS, COL_BITS and ADDR_BITS, defaults 5, 7 and 11: index widths, with ROWS*COLS <= 2^ADDR_BITS.
REQ-004 SHALL have parameter TAB_WIDTH, default 8: tab-stop spacing.
REQ-005 SHALL have parameter AUTOWRAP, default 1: 1 = wrap at the last column, 0 = overwrite the last column.
REQ-006 SHALL have parameter CLEAR_CHAR, default 8'h20: fill byte for clears.
REQ-007 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rstn, input, width 1: reset, asynchronous assert and active-low.
REQ-009 SHALL have port data, input, width 8: command/character byte.
REQ-010 SHALL have port valid, input, width 1: data valid.
REQ-011 SHALL have port ready, output, width 1: byte accepted when valid && ready.
REQ-012 SHALL have ports new_char (output, 8), new_char_address (output, ADDR_BITS) and new_char_wen (output, 1): char buffer write.
REQ-013 SHALL have ports new_cursor_x (output, COL_BITS), new_cursor_y (output, ROW_BITS) and new_cursor_wen (output, 1): cursor update.
REQ-014 SHALL have ports new_first_char (output, ADDR_BITS) and new_first_char_wen (output, 1): scroll origin update.
REQ-015 SHALL have port busy, output, width 1: high while a fill or clear is in progress.

Function
REQ-016 SHALL use FSM states INIT, IDLE, ESC, ESCY_ROW, ESCY_COL and FILL.
REQ-017 SHALL drive ready=1 only in IDLE, ESC, ESCY_ROW and ESCY_COL, and accept at most one byte per cycle.
REQ-018 SHALL compute the cell address as (first_char + y*COLS + x) mod (ROWS*COLS), using a width of ADDR_BITS+1 before the single conditional subtract.
REQ-019 SHALL, in IDLE on bytes 0x20..0x7E, write the byte at the cursor cell with new_char_wen high exactly one cycle after acceptance, then advance x.
REQ-020 SHALL, when x = COLS-1 and AUTOWRAP=1, set x=0 and perform a line feed; when AUTOWRAP=0, hold x.
REQ-021 SHALL handle control bytes in IDLE as follows: CR sets x=0; LF increments y; BS decrements x, saturating at 0; HT moves x to the next multiple of TAB_WIDTH, clamped to COLS-1; ESC moves to ESC; all other bytes are ignored.
REQ-022 SHALL, on a line feed at y = ROWS-1, scroll: new_first_char = (first_char + COLS) mod (ROWS*COLS), pulse new_first_char_wen for one cycle, hold y, then FILL the bottom row (COLS cells).
REQ-023 SHALL handle bytes in ESC as follows, then return to IDLE: A = up, B = down, C = right, D = left (all saturating, no scroll); H = home (0,0); J = FILL from the cursor to end of screen, (ROWS-y)*COLS-x cells; K = FILL from the cursor to end of line, COLS-x cells; E = home plus FILL of the whole screen; Y = go to ESCY_ROW; any other byte = ignore.
REQ-024 SHALL take in ESCY_ROW y = byte-32, and in ESCY_COL x = byte-32, each clamped to ROWS-1 / COLS-1, then return to IDLE.
REQ-025 SHALL write CLEAR_CHAR in FILL at one cell per cycle with new_char_wen high and consecutive wrapped addresses, hold busy=1 and ready=0, and go to IDLE after the final cell.
REQ-026 SHALL pulse new_cursor_wen for one cycle, carrying the new x/y, in the cycle after any cursor change, and never pulse it when the cursor is unchanged.
REQ-027 SHALL ignore valid while ready=0, leaving data unconsumed; the upstream holds data until acceptance.
REQ-028 SHALL always leave the cursor within 0..COLS-1 and 0..ROWS-1.

Reset
REQ-029 SHALL, while rstn=0, force all outputs to 0, cursor to (0,0), first_char to 0 and state to INIT.
REQ-030 SHALL, after rstn rises, perform INIT as a FILL of all ROWS*COLS cells from address 0 (busy=1, ready=0), then enter IDLE.
REQ-031 SHALL, on reset asserted mid-FILL or mid-escape, abort immediately with no further writes.

Structure
REQ-032 SHALL place the state enum and the control/escape byte constants (CR, LF, BS, HT, ESC) in shared package vt52_pkg.
REQ-033 SHALL use one sub-module, vt52_addr_gen: the wrapped cell-address computation of REQ-018.

Verification
REQ-034 SHALL verify: release reset -> exactly 2000 writes of 0x20 to addresses 0..1999, then ready=1.
REQ-035 SHALL verify: "A" at cursor (79,0) with AUTOWRAP=1 -> write 0x41 to address 79, cursor pulse (0,1).
REQ-036 SHALL verify: LF at y=24 with first_char=1960 -> new_first_char=40, then 80 writes at 1960..1999, wrapping to 0..39.
REQ-037 SHALL verify: ESC Y 0x25 0x2A -> cursor pulse (10,5); ESC Y 0x7F 0x7F -> clamped to (79,24).
REQ-038 SHALL verify: ESC K at (75,3) -> 5 fill writes at 315..319, busy high for 5 cycles, valid held and not consumed.
REQ-039 SHALL verify: rstn pulsed low mid ESC J -> writes stop within the cycle, and INIT restarts.
